// File: rtl/ff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// ff_bank_arbiter
//
// Sole writer of a WIDTH-bit flip-flop bank shared by NUM_REQ requesters.
// Requesters are served round-robin; each grant applies exactly one
// operation (load, toggle under mask, set under mask, clear under mask)
// and finishes with a one-cycle done pulse while the grant is still held.
//
// Ports
//   clk_i     : clock, rising-edge active
//   rst_ni    : asynchronous active-low reset, clears all state
//   req_i     : per-requester request level, held until its done
//   op_i      : per-requester opcode, requester i at [2i+1:2i]
//               00 load, 01 toggle, 10 set, 11 clear
//   data_i    : per-requester operand, requester i at [WIDTH*i +: WIDTH]
//   grant_o   : one-hot owner of the current operation, zero when idle
//   done_o    : one-cycle pulse, operation applied
//   busy_o    : high whenever an operation is in progress
//   bank_q_o  : current bank contents
//
// All outputs come straight from flops; nothing combinational reaches them
// from req_i, op_i or data_i.
// ---------------------------------------------------------------------------
module ff_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [2*NUM_REQ-1:0]     op_i,
    input  logic [WIDTH*NUM_REQ-1:0] data_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     done_o,
    output logic                     busy_o,
    output logic [WIDTH-1:0]         bank_q_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ACK  = 2'b10
    } state_e;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 done_q,  done_d;
    logic                 busy_q,  busy_d;
    logic [WIDTH-1:0]     bank_q,  bank_d;
    logic [IDX_W-1:0]     last_q,  last_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [1:0]           op_q,    op_d;
    logic [WIDTH-1:0]     data_q,  data_d;

    logic                 win_found_s;
    logic [IDX_W-1:0]     win_idx_s;

    // Round-robin pick: first set request scanning upward from last+1, wrapping.
    always_comb begin : p_arb
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found_s && req_i[cand_idx]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx;
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Next-state and output computation for the IDLE/EXEC/ACK sequence.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        bank_d  = bank_q;
        last_d  = last_q;
        owner_d = owner_q;
        op_d    = op_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    // Operands are captured here; later input changes are ignored.
                    state_d = EXEC;
                    owner_d = win_idx_s;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    op_d    = op_i[2*win_idx_s +: 2];
                    data_d  = data_i[WIDTH*win_idx_s +: WIDTH];
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_LOAD:   bank_d = data_q;
                    OP_TOGGLE: bank_d = bank_q ^ data_q;
                    OP_SET:    bank_d = bank_q | data_q;
                    OP_CLEAR:  bank_d = bank_q & ~data_q;
                    default:   bank_d = bank_q;
                endcase
                done_d  = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                // Owner becomes the lowest priority for the next arbitration.
                last_d  = owner_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            bank_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            op_q    <= 2'b00;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            bank_q  <= bank_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign grant_o  = grant_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign bank_q_o = bank_q;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ff_bank_arbiter
//
// Directed stimulus with hand-computed expectations, plus a transaction-level
// model (round-robin pick, a cycle count since grant, and the bank value)
// that is compared with the DUT outputs on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_ff_bank_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  req_v = 4'b0000;
    logic [7:0]  op_v = 8'h00;
    logic [31:0] data_v = 32'h0;
    logic [3:0]  grant_o;
    logic        done_o;
    logic        busy_o;
    logic [7:0]  bank_q_o;

    int vectors = 0;
    int miscompares = 0;

    ff_bank_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_v),
        .op_i     (op_v),
        .data_i   (data_v),
        .grant_o  (grant_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .bank_q_o (bank_q_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt;     // cycles since grant: 0 idle, 1 operation pending, 2 done visible
    int         m_last;
    int         m_owner;
    logic [1:0] m_op;
    logic [7:0] m_data;
    logic [7:0] m_bank;

    function automatic int rr_pick(input int last, input logic [3:0] r);
        int pick;
        pick = -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c;
            c = (last + i) % NUM_REQ;
            if (pick < 0 && r[c]) pick = c;
        end
        return pick;
    endfunction

    function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] b, input logic [7:0] d);
        case (op)
            2'b00:   return d;
            2'b01:   return b ^ d;
            2'b10:   return b | d;
            default: return b & ~d;
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cnt   <= 0;
            m_last  <= NUM_REQ - 1;
            m_owner <= 0;
            m_bank  <= 8'h00;
            m_op    <= 2'b00;
            m_data  <= 8'h00;
        end else if (m_cnt == 0) begin
            if (rr_pick(m_last, req_v) >= 0) begin
                m_owner <= rr_pick(m_last, req_v);
                m_op    <= op_v[2*rr_pick(m_last, req_v) +: 2];
                m_data  <= data_v[8*rr_pick(m_last, req_v) +: 8];
                m_cnt   <= 1;
            end
        end else if (m_cnt == 1) begin
            m_bank <= apply_op(m_op, m_bank, m_data);
            m_cnt  <= 2;
        end else begin
            m_last <= m_owner;
            m_cnt  <= 0;
        end
    end

    always @(negedge clk_i) begin
        check("model_grant", {28'h0, grant_o}, (m_cnt != 0) ? (32'd1 << m_owner) : 32'd0);
        check("model_done",  {31'h0, done_o},  {31'h0, (m_cnt == 2)});
        check("model_busy",  {31'h0, busy_o},  {31'h0, (m_cnt != 0)});
        check("model_bank",  {24'h0, bank_q_o}, {24'h0, m_bank});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] op, input logic [7:0] d);
        req_v[idx]         = 1'b1;
        op_v[2*idx +: 2]   = op;
        data_v[8*idx +: 8] = d;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
        check("done_wait", {31'h0, done_o}, 32'd1);
    endtask

    task automatic do_op(input int idx, input logic [1:0] op, input logic [7:0] d);
        set_req(idx, op, d);
        tick();
        wait_done();
        req_v[idx] = 1'b0;
        tick();
    endtask

    logic [3:0] rr_seen [5];
    int         rr_time [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_grant", {28'h0, grant_o}, 32'h0);
        check("rst_bank",  {24'h0, bank_q_o}, 32'h0);
        check("rst_busy",  {31'h0, busy_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single load by requester 2
        set_req(2, 2'b00, 8'h3C);
        tick();
        check("load_grant", {28'h0, grant_o}, 32'h4);
        check("load_busy",  {31'h0, busy_o}, 32'h1);
        tick();
        check("load_bank",  {24'h0, bank_q_o}, 32'h3C);
        check("load_done",  {31'h0, done_o}, 32'h1);
        req_v[2] = 1'b0;
        tick();
        check("load_grant_off", {28'h0, grant_o}, 32'h0);
        check("load_done_off",  {31'h0, done_o}, 32'h0);
        tick();

        // Mask operations starting from 8'hF0
        do_op(1, 2'b00, 8'hF0);
        check("bank_F0", {24'h0, bank_q_o}, 32'hF0);
        do_op(1, 2'b01, 8'hFF);
        check("toggle", {24'h0, bank_q_o}, 32'h0F);
        do_op(1, 2'b10, 8'h01);
        check("set", {24'h0, bank_q_o}, 32'h0F);
        do_op(1, 2'b11, 8'h0F);
        check("clear", {24'h0, bank_q_o}, 32'h00);
        do_op(0, 2'b00, 8'h5A);
        do_op(0, 2'b10, 8'h00);
        check("zero_mask", {24'h0, bank_q_o}, 32'h5A);

        // Round-robin fairness: make requester 3 the last owner first
        do_op(3, 2'b00, 8'h99);
        set_req(0, 2'b00, 8'h11);
        set_req(1, 2'b00, 8'h22);
        set_req(2, 2'b00, 8'h33);
        set_req(3, 2'b00, 8'h44);
        begin
            int k = 0;
            int cyc = 0;
            logic [3:0] prevg = 4'b0000;
            while (k < 5 && cyc < 30) begin
                tick();
                cyc++;
                if (grant_o != 4'b0000 && grant_o != prevg) begin
                    rr_seen[k] = grant_o;
                    rr_time[k] = cyc;
                    k++;
                end
                prevg = grant_o;
            end
            check("rr_count", k, 5);
        end
        check("rr_g0", {28'h0, rr_seen[0]}, 32'h1);
        check("rr_g1", {28'h0, rr_seen[1]}, 32'h2);
        check("rr_g2", {28'h0, rr_seen[2]}, 32'h4);
        check("rr_g3", {28'h0, rr_seen[3]}, 32'h8);
        check("rr_g4", {28'h0, rr_seen[4]}, 32'h1);
        for (int i = 1; i < 5; i++) check("rr_spacing", rr_time[i] - rr_time[i-1], 3);
        wait_done();
        req_v = 4'b0000;
        tick();
        check("rr_bank", {24'h0, bank_q_o}, 32'h11);

        // Mid-operation change: latched load must win
        set_req(0, 2'b00, 8'h77);
        tick();
        op_v[1:0]   = 2'b01;
        data_v[7:0] = 8'hFF;
        req_v[0]    = 1'b0;
        tick();
        check("midop_done", {31'h0, done_o}, 32'h1);
        check("midop_bank", {24'h0, bank_q_o}, 32'h77);
        tick();
        check("midop_done_once", {31'h0, done_o}, 32'h0);
        tick();
        check("midop_idle", {28'h0, grant_o}, 32'h0);

        // Wrap priority: last=3, requesters 0 and 3 pending
        do_op(3, 2'b00, 8'h99);
        set_req(0, 2'b00, 8'h01);
        set_req(3, 2'b00, 8'h03);
        tick();
        check("wrap_first", {28'h0, grant_o}, 32'h1);
        wait_done();
        tick();
        tick();
        check("wrap_second", {28'h0, grant_o}, 32'h8);
        wait_done();
        req_v = 4'b0000;
        tick();
        check("wrap_bank", {24'h0, bank_q_o}, 32'h03);

        // Asynchronous reset in the middle of an operation
        do_op(2, 2'b00, 8'hA5);
        check("pre_rst_bank", {24'h0, bank_q_o}, 32'hA5);
        set_req(1, 2'b00, 8'h5A);
        tick();
        check("pre_rst_grant", {28'h0, grant_o}, 32'h2);
        rst_ni = 1'b0;
        #1;
        check("arst_grant", {28'h0, grant_o}, 32'h0);
        check("arst_bank",  {24'h0, bank_q_o}, 32'h0);
        check("arst_busy",  {31'h0, busy_o}, 32'h0);
        check("arst_done",  {31'h0, done_o}, 32'h0);
        @(negedge clk_i);
        set_req(0, 2'b00, 8'hC1);
        set_req(1, 2'b00, 8'hC2);
        set_req(2, 2'b00, 8'hC3);
        set_req(3, 2'b00, 8'hC4);
        repeat (2) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("post_rst_grant", {28'h0, grant_o}, 32'h1);
        wait_done();
        req_v = 4'b0000;
        check("post_rst_bank", {24'h0, bank_q_o}, 32'hC1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
